// File: rtl/accel_pkg.sv
// Shared types for the accelerator job dispatcher: engine encodings,
// per-engine FSM states and the queued job record.
package accel_pkg;

  localparam int unsigned INDEX_W = 11;
  localparam int unsigned NUM_ENG = 3;

  typedef enum logic [1:0] {
    ENG_HASH    = 2'd0,
    ENG_ENC     = 2'd1,
    ENG_DEC     = 2'd2,
    ENG_ILLEGAL = 2'd3
  } eng_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } eng_state_e;

  typedef struct packed {
    eng_type_e            etype;
    logic [INDEX_W-1:0]   index;
  } job_t;

endpackage

// File: rtl/accel_job_fifo.sv
// In-order job FIFO. Pointers carry one extra MSB so full and empty
// are distinguishable when the low bits match.
module accel_job_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/accel_dispatch.sv
// Job scheduler between CPU accelerator requests and the hash/encrypt/
// decrypt engines. Optional per-job watchdog: ACCEL_DISPATCH_TIMEOUT_EN.
module accel_dispatch
  import accel_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [1:0]             req_type,
  input  logic [INDEX_W-1:0]     req_index,
  output logic                   req_ready,
  output logic                   h_start,
  output logic                   e_start,
  output logic                   d_start,
  output logic [INDEX_W-1:0]     eng_index,
  input  logic                   h_done_in,
  input  logic                   e_done_in,
  input  logic                   d_done_in,
  output logic                   cpu_h_done,
  output logic                   cpu_e_done,
  output logic                   cpu_d_done,
  output logic [2:0]             busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   err_illegal,
  output logic                   err_spurious,
  output logic [2:0]             timeout_err
);

  eng_state_e         state_q [NUM_ENG];
  eng_state_e         state_d [NUM_ENG];
  logic [2:0]         start_q, cpu_done_q, cpu_done_d, tmo_q, tmo_d;
  logic [2:0]         done_in, disp_vec, spur_d, expire;
  logic [INDEX_W-1:0] eng_index_q;
  logic               err_illegal_q, err_spurious_q;
  logic               fifo_full, fifo_empty, push, dispatch;
  job_t               head, wjob;

  assign done_in   = {d_done_in, e_done_in, h_done_in};
  assign req_ready = !fifo_full && !rst;
  assign push      = req_valid && req_ready && (req_type != ENG_ILLEGAL);
  assign wjob      = '{etype: eng_type_e'(req_type), index: req_index};

  accel_job_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(job_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (dispatch),
    .wdata_i (wjob),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Head-of-line dispatch decision against the registered engine state.
  always_comb begin
    disp_vec = '0;
    if (!fifo_empty) begin
      case (head.etype)
        ENG_HASH: disp_vec[0] = (state_q[0] == ST_IDLE);
        ENG_ENC:  disp_vec[1] = (state_q[1] == ST_IDLE);
        ENG_DEC:  disp_vec[2] = (state_q[2] == ST_IDLE);
        default:  disp_vec    = '0;
      endcase
    end
    dispatch = |disp_vec;
  end

`ifdef ACCEL_DISPATCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q [NUM_ENG];

  // Watchdog counters: cleared on launch, counting while the engine is busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ENG; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENG; i++) begin
        if (disp_vec[i])                cnt_q[i] <= '0;
        else if (state_q[i] == ST_BUSY) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  // Expiry lands on the TIMEOUT_CYCLES-th busy cycle.
  always_comb begin
    expire = '0;
    for (int unsigned i = 0; i < NUM_ENG; i++)
      expire[i] = (state_q[i] == ST_BUSY) && (cnt_q[i] == CNT_W'(TIMEOUT_CYCLES - 1));
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire         = '0;
`endif

  // Per-engine IDLE/BUSY transitions; a real done beats a same-cycle expiry.
  always_comb begin
    cpu_done_d = '0;
    spur_d     = '0;
    tmo_d      = '0;
    for (int unsigned i = 0; i < NUM_ENG; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (disp_vec[i]) state_d[i] = ST_BUSY;
          if (done_in[i])  spur_d[i]  = 1'b1;
        end
        ST_BUSY: begin
          if (done_in[i]) begin
            state_d[i]    = ST_IDLE;
            cpu_done_d[i] = 1'b1;
          end else if (expire[i]) begin
            state_d[i] = ST_IDLE;
            tmo_d[i]   = 1'b1;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  // Registered state, launch pulses, held index and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ENG; i++) state_q[i] <= ST_IDLE;
      start_q        <= '0;
      eng_index_q    <= '0;
      cpu_done_q     <= '0;
      tmo_q          <= '0;
      err_illegal_q  <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENG; i++) state_q[i] <= state_d[i];
      start_q        <= disp_vec;
      if (dispatch) eng_index_q <= head.index;
      cpu_done_q     <= cpu_done_d;
      tmo_q          <= tmo_d;
      err_illegal_q  <= req_valid && req_ready && (req_type == ENG_ILLEGAL);
      err_spurious_q <= |spur_d;
    end
  end

  // Busy vector view of the engine FSMs.
  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < NUM_ENG; i++) busy[i] = (state_q[i] == ST_BUSY);
  end

  assign {d_start, e_start, h_start}          = start_q;
  assign {cpu_d_done, cpu_e_done, cpu_h_done} = cpu_done_q;
  assign eng_index    = eng_index_q;
  assign err_illegal  = err_illegal_q;
  assign err_spurious = err_spurious_q;
  assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_accel_dispatch.sv
// Directed bench for accel_dispatch (DEPTH=4, TIMEOUT_CYCLES=16).
module tb_accel_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_type;
  logic [10:0] req_index;
  logic        req_ready;
  logic        h_start, e_start, d_start;
  logic [10:0] eng_index;
  logic        h_done_in, e_done_in, d_done_in;
  logic        cpu_h_done, cpu_e_done, cpu_d_done;
  logic [2:0]  busy;
  logic [2:0]  fifo_count;
  logic        err_illegal, err_spurious;
  logic [2:0]  timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  accel_dispatch #(
    .DEPTH          (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_type     (req_type),
    .req_index    (req_index),
    .req_ready    (req_ready),
    .h_start      (h_start),
    .e_start      (e_start),
    .d_start      (d_start),
    .eng_index    (eng_index),
    .h_done_in    (h_done_in),
    .e_done_in    (e_done_in),
    .d_done_in    (d_done_in),
    .cpu_h_done   (cpu_h_done),
    .cpu_e_done   (cpu_e_done),
    .cpu_d_done   (cpu_d_done),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .err_illegal  (err_illegal),
    .err_spurious (err_spurious),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] t, input logic [10:0] idx);
    req_valid = 1'b1;
    req_type  = t;
    req_index = idx;
  endtask

  function automatic logic [2:0] starts();
    return {d_start, e_start, h_start};
  endfunction

  function automatic logic [2:0] cdone();
    return {cpu_d_done, cpu_e_done, cpu_h_done};
  endfunction

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_type = '0; req_index = '0;
    h_done_in = 1'b0; e_done_in = 1'b0; d_done_in = 1'b0;
    #3;
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_index", eng_index, 0);
    chk("rst_starts", starts(), 0);
    chk("rst_tmo", timeout_err, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", req_ready, 1);

    // Single hash job: start one edge after acceptance.
    req(2'd0, 11'h155);
    tick();
    req_valid = 1'b0;
    chk("s1_count_acc", fifo_count, 1);
    chk("s1_no_start_yet", starts(), 0);
    tick();
    chk("s1_h_start", starts(), 3'b001);
    chk("s1_index", eng_index, 11'h155);
    chk("s1_busy", busy, 3'b001);
    chk("s1_count_pop", fifo_count, 0);
    tick();
    chk("s1_start_pulse", starts(), 0);
    h_done_in = 1'b1;
    tick();
    h_done_in = 1'b0;
    chk("s1_cpu_done", cdone(), 3'b001);
    chk("s1_busy_clr", busy, 0);
    tick();
    chk("s1_cpu_done_pulse", cdone(), 0);
    chk("s1_index_held", eng_index, 11'h155);

    // Hash, encrypt, decrypt on consecutive cycles.
    req(2'd0, 11'h001); tick();
    req(2'd1, 11'h002); tick();
    chk("s2_h_start", starts(), 3'b001);
    req(2'd2, 11'h003); tick();
    req_valid = 1'b0;
    chk("s2_e_start", starts(), 3'b010);
    chk("s2_e_index", eng_index, 11'h002);
    tick();
    chk("s2_d_start", starts(), 3'b100);
    chk("s2_d_index", eng_index, 11'h003);
    chk("s2_busy_all", busy, 3'b111);
    e_done_in = 1'b1; d_done_in = 1'b1;
    tick();
    e_done_in = 1'b0; d_done_in = 1'b0;
    chk("s2_ed_done", cdone(), 3'b110);
    chk("s2_busy_h", busy, 3'b001);
    h_done_in = 1'b1;
    tick();
    h_done_in = 1'b0;
    chk("s2_h_done", cdone(), 3'b001);
    chk("s2_busy_none", busy, 0);

    // Head-of-line blocking: encrypt waits behind second hash.
    req(2'd0, 11'h010); tick();
    req(2'd0, 11'h011); tick();
    req(2'd1, 11'h012); tick();
    req_valid = 1'b0;
    chk("s3_count_blk", fifo_count, 2);
    tick();
    chk("s3_enc_blocked", starts(), 0);
    chk("s3_busy_blk", busy, 3'b001);
    h_done_in = 1'b1;
    tick();
    h_done_in = 1'b0;
    chk("s3_no_b2b", starts(), 0);
    chk("s3_cpu_h", cdone(), 3'b001);
    tick();
    chk("s3_h2_start", starts(), 3'b001);
    chk("s3_h2_index", eng_index, 11'h011);
    chk("s3_count_1", fifo_count, 1);
    tick();
    chk("s3_e_start", starts(), 3'b010);
    chk("s3_e_index", eng_index, 11'h012);
    chk("s3_busy_he", busy, 3'b011);
    h_done_in = 1'b1; e_done_in = 1'b1;
    tick();
    h_done_in = 1'b0; e_done_in = 1'b0;
    chk("s3_both_done", cdone(), 3'b011);

    // Fill: one hash running, four more queued behind it.
    for (int i = 0; i < 5; i++) begin
      req(2'd0, 11'(11'h020 + i));
      tick();
    end
    chk("s4_full_count", fifo_count, 4);
    chk("s4_not_ready", req_ready, 0);
    req(2'd1, 11'h7FF);
    tick();
    req_valid = 1'b0;
    chk("s4_count_held", fifo_count, 4);

    // Asynchronous reset mid-job clears everything without a clock edge.
    rst = 1'b1;
    #1;
    chk("s4_rst_busy", busy, 0);
    chk("s4_rst_count", fifo_count, 0);
    chk("s4_rst_index", eng_index, 0);
    tick();
    rst = 1'b0;
    h_done_in = 1'b1;
    tick();
    h_done_in = 1'b0;
    chk("s4_no_done_after_rst", cdone(), 0);
    chk("s4_spur_after_rst", err_spurious, 1);
    tick();

    // Illegal type is dropped; spurious done flagged.
    req(2'd3, 11'h0AA);
    tick();
    req_valid = 1'b0;
    chk("s5_illegal", err_illegal, 1);
    chk("s5_count", fifo_count, 0);
    tick();
    chk("s5_illegal_pulse", err_illegal, 0);
    chk("s5_no_start", starts(), 0);
    e_done_in = 1'b1;
    tick();
    e_done_in = 1'b0;
    chk("s5_spurious", err_spurious, 1);
    chk("s5_no_cpu_e", cdone(), 0);
    tick();
    chk("s5_spur_pulse", err_spurious, 0);

`ifdef ACCEL_DISPATCH_TIMEOUT_EN
    // Decrypt never completes: watchdog fires on the 16th busy cycle.
    req(2'd2, 11'h3C3); tick();
    req_valid = 1'b0;
    tick();
    chk("t_d_start", starts(), 3'b100);
    for (int i = 0; i < 15; i++) tick();
    chk("t_still_busy", busy, 3'b100);
    chk("t_no_tmo_yet", timeout_err, 0);
    tick();
    chk("t_tmo", timeout_err, 3'b100);
    chk("t_busy_clr", busy, 0);
    chk("t_no_cpu_d", cdone(), 0);
    tick();
    chk("t_tmo_pulse", timeout_err, 0);
`else
    // Without the watchdog a stuck job stays busy indefinitely.
    req(2'd2, 11'h3C3); tick();
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("nt_still_busy", busy, 3'b100);
    chk("nt_no_tmo", timeout_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
